// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with pending-write scoreboard.
//   DEFAULT_DATA_W : default register width
//   DEFAULT_ADDR_W : default register index width
//   NUM_REGS       : register count for the default index width
//   reg_idx_t      : register index at the default width
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 4;
    localparam int unsigned NUM_REGS       = 2 ** DEFAULT_ADDR_W;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/pend_counter.sv
// Per-register count of issued-but-unretired writes.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : an accepted issue targets this register
//   dec      : a writeback targets this register (ignored while the count is zero)
//   clr      : squash all pending writes; dominates inc/dec
//   cnt      : current pending count
//   full     : count is all-ones (further issues must stall)
//   zero     : nothing pending
module pend_counter
    import regfile_pkg::*;
#(
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] cnt,
    output logic              full,
    output logic              zero
);

    logic dec_ok;

    // A retire with nothing pending is an underflow; the count must not wrap.
    assign dec_ok = dec && !zero;
    assign full   = &cnt;
    assign zero   = (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec_ok) begin
            cnt <= cnt + PEND_W'(1);
        end else if (dec_ok && !inc) begin
            cnt <= cnt - PEND_W'(1);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with N combinational read ports, one writeback port, optional
// writeback-to-read bypass and a per-register pending-write scoreboard.
//   clk, rst      : clock, asynchronous active-low reset
//   rd_addr       : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data       : packed read data (combinational)
//   rd_busy       : per read port, register still awaits an unretired write
//   issue_en      : ID issues an instruction writing issue_dest
//   issue_dest    : destination of the issued instruction
//   issue_stall   : issue refused this cycle, destination counter saturated
//   wb_en         : writeback valid
//   wb_dest       : writeback destination
//   wb_data       : writeback data
//   flush         : squash every pending write
//   err_underflow : sticky, writeback seen with nothing pending
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned PEND_W = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_dest,
    output logic                     issue_stall,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_dest,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     flush,
    output logic                     err_underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [PEND_W-1:0] pend_cnt [DEPTH];
    logic [DEPTH-1:0]  pend_full;
    logic [DEPTH-1:0]  pend_zero;
    logic [DEPTH-1:0]  inc_vec;
    logic [DEPTH-1:0]  dec_vec;

    // A same-cycle writeback does not lift the stall: it only looks at the registered count.
    assign issue_stall = issue_en && pend_full[issue_dest];

    // One pending counter per architectural register.
    for (genvar r = 0; r < DEPTH; r++) begin : g_pend
        assign inc_vec[r] = issue_en && !issue_stall && (issue_dest == ADDR_W'(r));
        assign dec_vec[r] = wb_en && (wb_dest == ADDR_W'(r));

        pend_counter #(
            .PEND_W (PEND_W)
        ) u_pend (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc_vec[r]),
            .dec  (dec_vec[r]),
            .clr  (flush),
            .cnt  (pend_cnt[r]),
            .full (pend_full[r]),
            .zero (pend_zero[r])
        );
    end

    // Register storage; flush does not block the writeback data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_dest] <= wb_data;
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_underflow <= 1'b0;
        end else if (wb_en && pend_zero[wb_dest]) begin
            err_underflow <= 1'b1;
        end
    end

    // Read muxes with bypass; bypass is gated by reset so reads show 0 while held.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic              hit;
        rd_data = '0;
        rd_busy = '0;
        a       = '0;
        hit     = 1'b0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            a   = rd_addr[i*ADDR_W +: ADDR_W];
            hit = BYPASS && rst && wb_en && (wb_dest == a);
            rd_data[i*DATA_W +: DATA_W] = hit ? wb_data : regs[a];
            // The last pending write retiring this cycle counts as available when bypassed.
            rd_busy[i] = (pend_cnt[a] > PEND_W'(1)) ||
                         ((pend_cnt[a] == PEND_W'(1)) && !hit);
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: a bypassing and a non-bypassing instance share all inputs
// and are compared every cycle against an array/counter reference model.
module tb_regfile_scoreboard;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned PEND_W = 2;
    localparam int unsigned DEPTH  = 16;
    localparam int          PMAX   = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data_b, rd_data_n;
    logic [NUM_RD-1:0]        busy_b, busy_n;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_dest;
    logic                     stall_b, stall_n;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_dest;
    logic [DATA_W-1:0]        wb_data;
    logic                     flush;
    logic                     err_b, err_n;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] m_regs [DEPTH];
    int                m_pend [DEPTH];
    bit                m_err;
    bit                in_reset;
    int                cand [$];

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_RD (NUM_RD), .PEND_W (PEND_W), .BYPASS (1'b1)
    ) dut_byp (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data_b), .rd_busy (busy_b),
        .issue_en (issue_en), .issue_dest (issue_dest), .issue_stall (stall_b),
        .wb_en (wb_en), .wb_dest (wb_dest), .wb_data (wb_data), .flush (flush),
        .err_underflow (err_b)
    );

    regfile_scoreboard #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_RD (NUM_RD), .PEND_W (PEND_W), .BYPASS (1'b0)
    ) dut_nobyp (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data_n), .rd_busy (busy_n),
        .issue_en (issue_en), .issue_dest (issue_dest), .issue_stall (stall_n),
        .wb_en (wb_en), .wb_dest (wb_dest), .wb_data (wb_data), .flush (flush),
        .err_underflow (err_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < DEPTH; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        m_err = 1'b0;
    endtask

    // Expected outputs straight from the scoreboard rules.
    task automatic check_outputs();
        logic [ADDR_W-1:0] a;
        bit                hit;
        bit                stall;
        for (int i = 0; i < NUM_RD; i++) begin
            a   = rd_addr[i*ADDR_W +: ADDR_W];
            hit = wb_en && (wb_dest == a) && !in_reset;
            chk($sformatf("rd_data_byp[%0d]", i), 64'(rd_data_b[i*DATA_W +: DATA_W]),
                64'(hit ? wb_data : m_regs[a]));
            chk($sformatf("rd_data_nobyp[%0d]", i), 64'(rd_data_n[i*DATA_W +: DATA_W]),
                64'(m_regs[a]));
            chk($sformatf("rd_busy_byp[%0d]", i), 64'(busy_b[i]),
                64'((m_pend[a] > 1) || (m_pend[a] == 1 && !hit)));
            chk($sformatf("rd_busy_nobyp[%0d]", i), 64'(busy_n[i]), 64'(m_pend[a] >= 1));
        end
        stall = issue_en && (m_pend[issue_dest] == PMAX);
        chk("issue_stall_byp", 64'(stall_b), 64'(stall));
        chk("issue_stall_nobyp", 64'(stall_n), 64'(stall));
        chk("err_underflow_byp", 64'(err_b), 64'(m_err));
        chk("err_underflow_nobyp", 64'(err_n), 64'(m_err));
    endtask

    task automatic model_update();
        bit accept;
        bit retire;
        accept = issue_en && (m_pend[issue_dest] != PMAX);
        retire = wb_en && (m_pend[wb_dest] != 0);
        if (wb_en) begin
            m_regs[wb_dest] = wb_data;
            if (m_pend[wb_dest] == 0) m_err = 1'b1;
        end
        if (flush) begin
            for (int r = 0; r < DEPTH; r++) m_pend[r] = 0;
        end else begin
            if (accept) m_pend[issue_dest] = m_pend[issue_dest] + 1;
            if (retire) m_pend[wb_dest] = m_pend[wb_dest] - 1;
        end
    endtask

    task automatic drive(input bit ie, input int idst, input bit we, input int wdst,
                         input logic [31:0] wd, input bit fl, input int ra0, input int ra1);
        issue_en   = ie;
        issue_dest = ADDR_W'(idst);
        wb_en      = we;
        wb_dest    = ADDR_W'(wdst);
        wb_data    = wd;
        flush      = fl;
        rd_addr    = {ADDR_W'(ra1), ADDR_W'(ra0)};
    endtask

    // Inputs are applied just after a negedge; checks land mid-low-phase.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        in_reset = 1'b1;
        rst      = 1'b0;
        model_clear();
        drive(0, 0, 0, 0, 32'h0, 0, 0, 1);
        #2;
        chk("reset_rd_data", 64'(rd_data_b), 64'h0);
        chk("reset_busy", 64'(busy_b), 64'h0);
        check_outputs();
        @(negedge clk);
        rst      = 1'b1;
        in_reset = 1'b0;

        // Bypass: same-cycle forward vs. next-cycle visibility without bypass.
        drive(0, 0, 1, 3, 32'hDEADBEEF, 0, 3, 4);
        #1;
        chk("bypass_same_cycle", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
        chk("nobypass_old_value", 64'(rd_data_n[31:0]), 64'h0);
        step();
        drive(0, 0, 0, 0, 32'h0, 0, 3, 3);
        #1;
        chk("nobypass_next_cycle", 64'(rd_data_n[31:0]), 64'hDEADBEEF);
        chk("underflow_set", 64'(err_b), 64'h1);
        step();

        // Reset mid-run with a writeback on the read address.
        rst      = 1'b0;
        in_reset = 1'b1;
        model_clear();
        drive(0, 0, 1, 3, 32'h1234_5678, 0, 3, 5);
        #1;
        chk("midreset_rd_data", 64'(rd_data_b), 64'h0);
        chk("midreset_busy", 64'(busy_b), 64'h0);
        chk("midreset_err", 64'(err_b), 64'h0);
        check_outputs();
        @(negedge clk);
        rst      = 1'b1;
        in_reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 0, 3, 0);
        step();

        // Scoreboard saturation on r5.
        for (int k = 0; k < 3; k++) begin
            drive(1, 5, 0, 0, 32'h0, 0, 5, 0);
            step();
        end
        drive(1, 5, 0, 0, 32'h0, 0, 5, 0);
        #1;
        chk("stall_on_full", 64'(stall_b), 64'h1);
        step();
        drive(0, 0, 1, 5, 32'h0000_0501, 0, 5, 0);
        step();
        drive(0, 0, 0, 0, 32'h0, 0, 5, 0);
        #1;
        chk("busy_after_one_wb", 64'(busy_b[0]), 64'h1);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 5, 32'h0000_0502 + 32'(k), 0, 5, 0);
            step();
        end
        drive(0, 0, 0, 0, 32'h0, 0, 5, 0);
        #1;
        chk("busy_cleared_byp", 64'(busy_b[0]), 64'h0);
        chk("busy_cleared_nobyp", 64'(busy_n[0]), 64'h0);
        step();

        // Simultaneous issue and writeback on r7.
        drive(1, 7, 0, 0, 32'h0, 0, 7, 0);
        step();
        drive(1, 7, 1, 7, 32'h7777_0007, 0, 7, 0);
        step();
        drive(0, 0, 0, 0, 32'h0, 0, 7, 0);
        #1;
        chk("simul_busy", 64'(busy_b[0]), 64'h1);
        chk("simul_data", 64'(rd_data_b[31:0]), 64'h7777_0007);
        step();
        drive(0, 0, 1, 7, 32'h7777_0008, 0, 7, 0);
        step();

        // Flush with a same-cycle issue, then a stale writeback.
        drive(1, 1, 0, 0, 32'h0, 0, 1, 2);
        step();
        step();
        drive(1, 2, 0, 0, 32'h0, 0, 1, 2);
        step();
        drive(1, 4, 0, 0, 32'h0, 1, 1, 4);
        step();
        drive(0, 0, 0, 0, 32'h0, 0, 1, 4);
        #1;
        chk("flush_busy_r1", 64'(busy_b[0]), 64'h0);
        chk("flush_busy_r4", 64'(busy_b[1]), 64'h0);
        chk("flush_no_err_yet", 64'(err_b), 64'h0);
        step();
        drive(0, 0, 1, 1, 32'hCAFE_0001, 0, 2, 0);
        step();
        drive(0, 0, 0, 0, 32'h0, 0, 1, 0);
        #1;
        chk("stale_wb_err", 64'(err_b), 64'h1);
        chk("stale_wb_data", 64'(rd_data_n[31:0]), 64'hCAFE_0001);
        step();

        // Fresh state for the random phase so underflow remains observable.
        rst      = 1'b0;
        in_reset = 1'b1;
        model_clear();
        drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
        #1;
        check_outputs();
        @(negedge clk);
        rst      = 1'b1;
        in_reset = 1'b0;

        for (int n = 0; n < 800; n++) begin
            issue_en   = ($urandom_range(0, 2) != 0);
            issue_dest = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 3));
            cand.delete();
            for (int r = 0; r < DEPTH; r++) begin
                if (m_pend[r] > 0) cand.push_back(r);
            end
            wb_en   = 1'b0;
            wb_dest = '0;
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                wb_en   = 1'b1;
                wb_dest = ADDR_W'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if ($urandom_range(0, 150) == 0) begin
                wb_en   = 1'b1;
                wb_dest = ADDR_W'($urandom);
            end
            wb_data = $urandom;
            flush   = ($urandom_range(0, 40) == 0);
            for (int i = 0; i < NUM_RD; i++) begin
                rd_addr[i*ADDR_W +: ADDR_W] = ($urandom_range(0, 3) == 0) ? wb_dest
                                             : ADDR_W'($urandom_range(0, 5));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
